mar_arbiter: RTL and testbench
==============================

Name: mar_arbiter

Overview:
- Shares the single 15-bit MAR between two requesters: instruction fetch (if_*) and data/operand access (dt_*).
- Sequences MAR load (mar_we) and memory read enable (mar_re), waits for the memory to report ready or for a timeout, then returns a one-cycle done pulse to the owning requester.
- Sits between the control unit's fetch/execute paths and the MAR/memory interface.
- Two-requester round-robin arbitration prevents starvation.

Parameters:
- ADDR_W, 15, address width; must match the MAR width.
- TIMEOUT, 8, maximum number of ACCESS cycles to wait for mem_ready before aborting with err. Must be >= 1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch address; sampled only at grant
- if_gnt  out  1  fetch owns MAR (LOAD and ACCESS states)
- if_done  out  1  one-cycle completion pulse to fetch
- dt_req  in  1  data request; held high until dt_done
- dt_addr  in  ADDR_W  data address; sampled only at grant
- dt_gnt  out  1  data path owns MAR
- dt_done  out  1  one-cycle completion pulse to data path
- err  out  1  valid with a done pulse; 1 = access timed out
- mar_addr  out  ADDR_W  address to the MAR in1
- mar_we  out  1  MAR load strobe
- mar_re  out  1  MAR/memory read enable
- mem_ready  in  1  memory has completed the access

Behaviour:
- FSM states are IDLE, LOAD, ACCESS and RESP. All outputs are registered and decoded from state, owner and the latched address.
- Reset (asynchronous, any state, including mid-access):
  - State returns to IDLE.
  - All gnt, done, err, mar_we and mar_re go to 0; mar_addr goes to 0; the wait counter goes to 0.
  - last_owner resets to DATA, so fetch wins the first tie.
  - No done pulse is issued for an aborted transaction.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_owner.
  - On the grant edge: latch owner and the owner's address into the internal addr_q, set last_owner to the owner, and go to LOAD.
- LOAD (exactly 1 cycle):
  - The owner's gnt is 1, mar_we is 1, and mar_addr equals addr_q.
  - Go to ACCESS; clear the wait counter.
- ACCESS:
  - The owner's gnt is 1, mar_re is 1, and mar_we is 0.
  - If mem_ready is 1 on an edge: go to RESP with err_q = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (i.e. after TIMEOUT ACCESS cycles without ready), go to RESP with err_q = 1.
  - mem_ready takes precedence if it arrives in the same cycle the timeout would fire.
- RESP (exactly 1 cycle):
  - The owner's done is 1, err is err_q, gnt is 0, and mar_re is 0.
  - Always return to IDLE.
- Latency: a request sampled at edge N gives gnt/mar_we in cycle N+1 and mar_re from N+2. With mem_ready high at the first ACCESS edge, done is in cycle N+3 and the next grant is possible at edge N+4.
- Requester rules:
  - A requester must drop req on the edge after it sees done; it is therefore low in IDLE, so no double service.
  - Address changes after the grant edge are ignored, because addr_q is used.
  - req falling mid-transaction does not abort: the transaction completes and done still pulses.
- The non-owner's gnt and done stay 0 throughout; its req waits in place.
- mem_ready outside ACCESS is ignored.
- At most one gnt and at most one done are high in any cycle.

Test Plan:
- Reset then single fetch:
  - Stimulus: if_req=1, if_addr=15'h1234; mem_ready pulses on the 2nd ACCESS cycle.
  - Response: 1 cycle of if_gnt+mar_we with mar_addr=1234, then 2 cycles of mar_re, then if_done=1 with err=0 for 1 cycle, then IDLE.
- Simultaneous requests:
  - Stimulus: if_addr=0010, dt_addr=7FFF, both req=1 from reset, mem_ready=1 always.
  - Response: fetch is served first (mar_addr=0010), then data (7FFF), then fetch again if re-requested; grants alternate strictly.
- Timeout with TIMEOUT=8 and mem_ready=0:
  - Response: mar_re is high for exactly 8 cycles, then dt_done=1 and err=1.
  - Follow-up: a subsequent access with ready gives err=0.
- Ready/timeout collision:
  - Stimulus: mem_ready rises on the 8th ACCESS cycle.
  - Response: err=0.
- Address hold-off:
  - Stimulus: change dt_addr and drop dt_req during ACCESS.
  - Response: mar_addr holds the latched value; dt_done still pulses once.
- Reset mid-ACCESS:
  - Stimulus: assert rst asynchronously, between edges.
  - Response: all outputs are 0 immediately, with no done pulse; after release, a pending tie goes to fetch.

Source files
------------

// File: rtl/mar_arbiter.sv
// rtl/mar_arbiter.sv - Round-robin arbiter sequencing fetch and data accesses onto the shared MAR
module mar_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              dt_req,
    input  logic [ADDR_W-1:0] dt_addr,
    output logic              dt_gnt,
    output logic              dt_done,
    output logic              err,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mar_we,
    output logic              mar_re,
    input  logic              mem_ready
);

    // Counter only has to represent 0..TIMEOUT-1; the final increment is the exit itself.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DT} owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     cnt;
    logic              pick_dt;
    logic              own_dt;

    // Data wins only when fetch is idle or fetch was the previous owner.
    assign pick_dt  = dt_req && (!if_req || last_owner == OWN_IF);
    assign own_dt   = (owner == OWN_DT);
    assign mar_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_DT;
            addr_q     <= '0;
            cnt        <= '0;
            if_gnt     <= 1'b0;
            dt_gnt     <= 1'b0;
            if_done    <= 1'b0;
            dt_done    <= 1'b0;
            err        <= 1'b0;
            mar_we     <= 1'b0;
            mar_re     <= 1'b0;
        end else begin
            if_gnt  <= 1'b0;
            dt_gnt  <= 1'b0;
            if_done <= 1'b0;
            dt_done <= 1'b0;
            err     <= 1'b0;
            mar_we  <= 1'b0;
            mar_re  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dt_req) begin
                        owner      <= pick_dt ? OWN_DT : OWN_IF;
                        last_owner <= pick_dt ? OWN_DT : OWN_IF;
                        addr_q     <= pick_dt ? dt_addr : if_addr;
                        if_gnt     <= !pick_dt;
                        dt_gnt     <= pick_dt;
                        mar_we     <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    cnt    <= '0;
                    if_gnt <= !own_dt;
                    dt_gnt <= own_dt;
                    mar_re <= 1'b1;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if_done <= !own_dt;
                        dt_done <= own_dt;
                        err     <= 1'b0;
                        state   <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        if_done <= !own_dt;
                        dt_done <= own_dt;
                        err     <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        if_gnt <= !own_dt;
                        dt_gnt <= own_dt;
                        mar_re <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mar_arbiter.sv
// tb/tb_mar_arbiter.sv - Vector table, hand sequences and randomized model checks for mar_arbiter
module tb_mar_arbiter;

    localparam int ADDR_W  = 15;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dt_req, mem_ready;
    logic [ADDR_W-1:0] if_addr, dt_addr;
    logic              if_gnt, if_done, dt_gnt, dt_done, err, mar_we, mar_re;
    logic [ADDR_W-1:0] mar_addr;
    logic [6:0]        obs;

    int n_pass  = 0;
    int n_total = 0;

    mar_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .dt_req(dt_req), .dt_addr(dt_addr), .dt_gnt(dt_gnt), .dt_done(dt_done),
        .err(err), .mar_addr(mar_addr), .mar_we(mar_we), .mar_re(mar_re),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign obs = {if_gnt, dt_gnt, if_done, dt_done, err, mar_we, mar_re};

    task automatic check(input string name, input logic [6:0] exp, input logic care,
                         input logic [ADDR_W-1:0] exp_addr);
        n_total++;
        if (obs !== exp || (care && mar_addr !== exp_addr))
            $display("FAIL %s: got gnt/done/err/we/re=%b addr=%h, want %b addr=%h",
                     name, obs, mar_addr, exp, exp_addr);
        else
            n_pass++;
    endtask

    // Entered between edges with the arbiter idle; leaves one cycle after the done pulse.
    task automatic do_txn(input logic ifr, input logic dtr,
                          input logic [ADDR_W-1:0] ifa, input logic [ADDR_W-1:0] dta,
                          input int d, input logic exp_dt, input logic [ADDR_W-1:0] exp_addr,
                          input int exp_k, input logic exp_err);
        if_req = ifr; dt_req = dtr; if_addr = ifa; dt_addr = dta;
        mem_ready = 1'($urandom % 2);
        @(posedge clk); #1;
        check("load", {!exp_dt, exp_dt, 2'b00, 1'b0, 1'b1, 1'b0}, 1'b1, exp_addr);
        if_addr = ADDR_W'($urandom); dt_addr = ADDR_W'($urandom);
        mem_ready = 1'($urandom % 2);
        for (int i = 0; i < exp_k; i++) begin
            @(posedge clk); #1;
            check("access", {!exp_dt, exp_dt, 2'b00, 1'b0, 1'b0, 1'b1}, 1'b1, exp_addr);
            if (i == 0 && ($urandom % 2) == 1) begin
                if (exp_dt) dt_req = 1'b0; else if_req = 1'b0;
            end
            dt_addr = ADDR_W'($urandom);
            mem_ready = (i == d);
        end
        @(posedge clk); #1;
        check("resp", {2'b00, !exp_dt, exp_dt, exp_err, 1'b0, 1'b0}, 1'b0, '0);
        if (exp_dt) dt_req = 1'b0; else if_req = 1'b0;
        mem_ready = 1'($urandom % 2);
        @(posedge clk); #1;
        check("idle", 7'b0, 1'b0, '0);
    endtask

    typedef struct {
        logic              ifr;
        logic              dtr;
        logic [ADDR_W-1:0] ifa;
        logic [ADDR_W-1:0] dta;
        int                d;
        logic              exp_dt;
        logic [ADDR_W-1:0] exp_addr;
        int                exp_k;
        logic              exp_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic              mdl_last;
        logic              pend_if, pend_dt, e_dt, e_err;
        logic [ADDR_W-1:0] ra, rb;
        int                d, e_k;

        // d = index of the ACCESS cycle whose closing edge sees mem_ready; >= TIMEOUT means never
        tbl[0] = '{1'b1, 1'b1, 15'h0010, 15'h7FFF, 0,  1'b0, 15'h0010, 1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 15'h0010, 15'h7FFF, 0,  1'b1, 15'h7FFF, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 15'h0010, 15'h7FFF, 0,  1'b0, 15'h0010, 1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 15'h1234, 15'h0000, 1,  1'b0, 15'h1234, 2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 15'h0000, 15'h0ABC, 99, 1'b1, 15'h0ABC, 8, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 15'h0000, 15'h0ABD, 0,  1'b1, 15'h0ABD, 1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 15'h0F0F, 15'h5555, 7,  1'b0, 15'h0F0F, 8, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 15'h0F0F, 15'h5555, 8,  1'b1, 15'h5555, 8, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 15'h4000, 15'h2000, 3,  1'b0, 15'h4000, 4, 1'b0};

        rst = 1'b1; if_req = 1'b0; dt_req = 1'b0; mem_ready = 1'b0;
        if_addr = '0; dt_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 7'b0, 1'b1, '0);
        #3 rst = 1'b0;

        for (int r = 0; r < 9; r++)
            do_txn(tbl[r].ifr, tbl[r].dtr, tbl[r].ifa, tbl[r].dta, tbl[r].d,
                   tbl[r].exp_dt, tbl[r].exp_addr, tbl[r].exp_k, tbl[r].exp_err);

        // Fetch went last, so this tie goes to data; reset mid-access must re-arm fetch priority.
        if_req = 1'b1; dt_req = 1'b1; if_addr = 15'h1111; dt_addr = 15'h2222; mem_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_load", 7'b0100010, 1'b1, 15'h2222);
        @(posedge clk); #1;
        check("rst_access", 7'b0100001, 1'b1, 15'h2222);
        #3 rst = 1'b1;
        #1 check("rst_async", 7'b0, 1'b1, '0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_hold", 7'b0, 1'b1, '0);
        #3 rst = 1'b0; mem_ready = 1'b0;
        do_txn(1'b1, 1'b1, 15'h1111, 15'h2222, 0, 1'b0, 15'h1111, 1, 1'b0);
        mdl_last = 1'b0;

        pend_if = 1'b0; pend_dt = 1'b0;
        for (int n = 0; n < 80; n++) begin
            pend_if = pend_if | 1'($urandom % 2);
            pend_dt = pend_dt | 1'($urandom % 2);
            if (!pend_if && !pend_dt) begin
                if_req = 1'b0; dt_req = 1'b0; mem_ready = 1'($urandom % 2);
                @(posedge clk); #1;
                check("idle_rand", 7'b0, 1'b0, '0);
            end else begin
                ra = ADDR_W'($urandom); rb = ADDR_W'($urandom);
                d = int'($urandom_range(0, TIMEOUT + 1));
                e_dt  = (pend_if && pend_dt) ? !mdl_last : pend_dt;
                e_k   = (d < TIMEOUT) ? d + 1 : TIMEOUT;
                e_err = (d >= TIMEOUT);
                do_txn(pend_if, pend_dt, ra, rb, d, e_dt, e_dt ? rb : ra, e_k, e_err);
                mdl_last = e_dt;
                if (e_dt) pend_dt = 1'b0; else pend_if = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
